// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C master and the transaction arbiter in front of it.
package i2c_pkg;

    typedef enum logic [3:0] {
        MST_IDLE     = 4'd0,
        MST_START    = 4'd1,
        MST_ADDR     = 4'd2,
        MST_ACK_ADDR = 4'd3,
        MST_WDATA    = 4'd4,
        MST_ACK_W    = 4'd5,
        MST_RDATA    = 4'd6,
        MST_ACK_R    = 4'd7,
        MST_STOP     = 4'd8,
        MST_RSTART   = 4'd9
    } mst_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP,
        S_RECOVER
    } arb_state_e;

    localparam int START_TO_DEF = 16;
    localparam int DONE_TO_DEF  = 65535;
    localparam int TMR_W        = 16;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic            found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer in front of the single-shot I2C master: grants one
// requester, launches the master, waits for completion or timeout, responds, resets the master.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int START_TO = START_TO_DEF,
    parameter int DONE_TO  = DONE_TO_DEF,
    parameter int RST_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [NREQ-1:0]      req_da,
    input  logic [NREQ-1:0]      req_rep,
    input  logic [2*NREQ-1:0]    req_bytcount,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_err,
    output logic [31:0]          rsp_rdata,
    output logic                 mst_enable,
    output logic                 mst_rw,
    output logic                 mst_da,
    output logic                 mst_rep,
    output logic [1:0]           mst_bytcount,
    output logic [6:0]           mst_addr,
    output logic [31:0]          mst_din,
    output logic                 mst_rst_n,
    input  logic [3:0]           mst_state,
    input  logic [31:0]          mst_dout,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam logic [TMR_W-1:0] START_LIM = TMR_W'(START_TO - 1);
    localparam logic [TMR_W-1:0] DONE_LIM  = TMR_W'(DONE_TO - 1);
    localparam logic [7:0]       RCNT_LAST = 8'(RST_CYC - 1);

    arb_state_e       state, state_n;
    logic [NREQ-1:0]  gnt;
    logic             found;
    logic [1:0]       rr_ptr;
    logic [1:0]       gidx;
    logic [TMR_W-1:0] timer;
    logic [7:0]       rcnt;
    logic             err_q;
    logic             mst_idle, start_hit, done_hit;

    logic             d_rw, d_da, d_rep;
    logic [1:0]       d_bc;
    logic [6:0]       d_addr;
    logic [31:0]      d_wdata;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .found (found)
    );

    assign mst_idle  = (mst_state == MST_IDLE);
    assign start_hit = (timer >= START_LIM);
    assign done_hit  = (timer >= DONE_LIM);

    // Winner index and its descriptor slice.
    always_comb begin
        gidx    = '0;
        d_rw    = 1'b0;
        d_da    = 1'b0;
        d_rep   = 1'b0;
        d_bc    = '0;
        d_addr  = '0;
        d_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gidx    = 2'(i);
                d_rw    = req_rw[i];
                d_da    = req_da[i];
                d_rep   = req_rep[i];
                d_bc    = req_bytcount[2*i +: 2];
                d_addr  = req_addr[7*i +: 7];
                d_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    assign req_ready = (state == S_ARB) ? gnt : '0;
    assign rsp_err   = (state == S_RESP) && err_q;
    assign busy      = (state != S_IDLE);

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = (state == S_RESP) && (grant_id == 2'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (|req_valid) state_n = S_ARB;
            S_ARB:       state_n = found ? S_LAUNCH : S_IDLE;
            S_LAUNCH:    state_n = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!mst_idle)      state_n = S_WAIT_DONE;
                else if (start_hit) state_n = S_RESP;
            end
            S_WAIT_DONE: if (mst_idle || done_hit) state_n = S_RESP;
            S_RESP:      state_n = S_RECOVER;
            S_RECOVER:   if (rcnt == RCNT_LAST) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            mst_rw       <= 1'b0;
            mst_da       <= 1'b0;
            mst_rep      <= 1'b0;
            mst_bytcount <= '0;
            mst_addr     <= '0;
            mst_din      <= '0;
            mst_enable   <= 1'b0;
            mst_rst_n    <= 1'b0;
            timer        <= '0;
            rcnt         <= '0;
            err_q        <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            // Enable and master reset follow the next state so they line up with it.
            mst_enable <= (state_n == S_LAUNCH) || (state_n == S_WAIT_BUSY) ||
                          (state_n == S_WAIT_DONE);
            mst_rst_n  <= (state_n != S_RECOVER);

            if (state == S_ARB && found) begin
                grant_id     <= gidx;
                rr_ptr       <= (gidx == 2'(NREQ - 1)) ? 2'd0 : gidx + 2'd1;
                mst_rw       <= d_rw;
                mst_da       <= d_da;
                mst_rep      <= d_rep;
                mst_bytcount <= d_bc;
                mst_addr     <= d_addr;
                mst_din      <= d_wdata;
            end

            if (state == S_LAUNCH || (state == S_WAIT_BUSY && !mst_idle))
                timer <= '0;
            else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && timer != '1)
                timer <= timer + 1'b1;

            if (state == S_LAUNCH) err_q <= 1'b0;

            if (state == S_WAIT_BUSY && mst_idle && start_hit) begin
                err_q     <= 1'b1;
                rsp_rdata <= '0;
            end

            if (state == S_WAIT_DONE) begin
                if (mst_idle) begin
                    err_q     <= 1'b0;
                    rsp_rdata <= mst_dout;
                end else if (done_hit) begin
                    err_q     <= 1'b1;
                    rsp_rdata <= '0;
                end
            end

            rcnt <= (state == S_RECOVER) ? rcnt + 8'd1 : 8'd0;
        end
    end

endmodule
